// File: rtl/muldiv_iter_if.sv
// Execute-stage handshake bundle for the iterative multiply/divide unit.
// The execute stage drives the master side; the unit is the slave.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 annul_i;
    logic [2:0]           op_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [2*WIDTH-1:0]   acc_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 dz_o;

    modport master (
        output start_i, annul_i, op_i, opdata1_i, opdata2_i, acc_i,
        input  result_o, ready_o, busy_o, dz_o
    );

    modport slave (
        input  start_i, annul_i, op_i, opdata1_i, opdata2_i, acc_i,
        output result_o, ready_o, busy_o, dz_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative one-bit-per-cycle multiply / multiply-accumulate / divide unit.
// Shift-add multiply and restoring divide share one 2*WIDTH work register.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_iter_if.slave bus
);
    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam int W2   = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  mag1_q, mag1_d;
    logic [WIDTH-1:0]  mag2_q, mag2_d;
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic [W2-1:0]     work_q, work_d;
    logic [W2-1:0]     res_q, res_d;
    logic              dz_q, dz_d;

    logic              in_div, in_zero, in_s1, in_s2, last, q_div;
    logic [WIDTH-1:0]  in1_mag, in2_mag;
    logic [WIDTH:0]    sum, sh;
    logic              ge;
    logic [W2-1:0]     step, prod, fin;
    logic [WIDTH-1:0]  quo, rem;

    assign in_div  = bus.op_i[1] & ~bus.op_i[2];
    assign in_zero = in_div && (bus.opdata2_i == '0);
    assign in_s1   = bus.op_i[0] & bus.opdata1_i[WIDTH-1];
    assign in_s2   = bus.op_i[0] & bus.opdata2_i[WIDTH-1];
    assign in1_mag = in_s1 ? -bus.opdata1_i : bus.opdata1_i;
    assign in2_mag = in_s2 ? -bus.opdata2_i : bus.opdata2_i;
    assign q_div   = op_q[1] & ~op_q[2];
    assign last    = (cnt_q == CNTW'(WIDTH - 1));

    // One iteration: multiplier/dividend bits live in the low half of work_q
    always_comb begin
        sum  = '0;
        sh   = '0;
        ge   = 1'b0;
        step = work_q;
        if (q_div) begin
            sh = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
            ge = (sh >= {1'b0, mag2_q});
            if (ge) sh = sh - {1'b0, mag2_q};
            step = {sh[WIDTH-1:0], work_q[WIDTH-2:0], ge};
        end else begin
            sum  = {1'b0, work_q[W2-1:WIDTH]}
                 + (work_q[0] ? {1'b0, mag1_q} : '0);
            step = {sum, work_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = step;
        quo  = step[WIDTH-1:0];
        rem  = step[W2-1:WIDTH];
        fin  = '0;
        if (q_div) begin
            if (s1_q ^ s2_q) quo = -quo;
            if (s1_q) rem = -rem;
            fin = {rem, quo};
        end else begin
            if (s1_q ^ s2_q) prod = -prod;
            if (!op_q[2]) fin = prod;
            else if (op_q[1]) fin = acc_q - prod;
            else fin = acc_q + prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            mag1_q  <= '0;
            mag2_q  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            work_q  <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mag1_q  <= mag1_d;
            mag2_q  <= mag2_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            work_q  <= work_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    // Annul wins over every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.annul_i)
                    state_d = in_zero ? DONE : CALC;
            end
            CALC: begin
                if (bus.annul_i || !bus.start_i) state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: begin
                if (bus.annul_i || !bus.start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        acc_d  = acc_q;
        mag1_d = mag1_q;
        mag2_d = mag2_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        work_d = work_q;
        res_d  = res_q;
        dz_d   = dz_q;
        unique case (state_q)
            IDLE: begin
                if (state_d != IDLE) begin
                    cnt_d  = '0;
                    op_d   = bus.op_i;
                    acc_d  = bus.acc_i;
                    mag1_d = in1_mag;
                    mag2_d = in2_mag;
                    s1_d   = in_s1;
                    s2_d   = in_s2;
                    work_d = {{WIDTH{1'b0}}, in_div ? in1_mag : in2_mag};
                    res_d  = '0;
                    dz_d   = in_zero;
                end
            end
            CALC: begin
                if (state_d == IDLE) begin
                    res_d = '0;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + CNTW'(1);
                    if (state_d == DONE) res_d = fin;
                end
            end
            DONE: begin
                if (state_d == IDLE) begin
                    res_d = '0;
                    dz_d  = 1'b0;
                end
            end
            default: begin
                res_d = '0;
                dz_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.ready_o  = (state_q == DONE);
        bus.busy_o   = (state_q == CALC);
        bus.result_o = res_q;
        bus.dz_o     = dz_q;
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: 32-bit and 8-bit instances against an
// arithmetic reference model, with directed corner and abort cases.
module tb_muldiv_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_r, annul_r, sel8;
    logic [2:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [63:0] acc_r;
    int          n_vec = 0;
    int          n_err = 0;

    muldiv_iter_if #(.WIDTH(32)) if32 ();
    muldiv_iter_if #(.WIDTH(8))  if8 ();

    muldiv_iter #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));
    muldiv_iter #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));

    assign if32.start_i   = start_r & ~sel8;
    assign if32.annul_i   = annul_r;
    assign if32.op_i      = op_r;
    assign if32.opdata1_i = a_r;
    assign if32.opdata2_i = b_r;
    assign if32.acc_i     = acc_r;
    assign if8.start_i    = start_r & sel8;
    assign if8.annul_i    = annul_r;
    assign if8.op_i       = op_r;
    assign if8.opdata1_i  = a_r[7:0];
    assign if8.opdata2_i  = b_r[7:0];
    assign if8.acc_i      = acc_r[15:0];

    logic [63:0] res_m;
    logic        rdy_m, busy_m, dz_m;
    always_comb begin
        if (sel8) begin
            res_m  = {48'b0, if8.result_o};
            rdy_m  = if8.ready_o;
            busy_m = if8.busy_o;
            dz_m   = if8.dz_o;
        end else begin
            res_m  = if32.result_o;
            rdy_m  = if32.ready_o;
            busy_m = if32.busy_o;
            dz_m   = if32.dz_o;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {dz, result} from plain integer arithmetic at width w
    function automatic logic [64:0] model(input int w, input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] acc);
        longint      sa, sb, q, r;
        logic [63:0] mw, m2, p;
        mw = (64'd1 << w) - 64'd1;
        m2 = (w == 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
        sa = longint'({32'b0, a} & mw);
        sb = longint'({32'b0, b} & mw);
        if (op[0]) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        if (op[1] && !op[2]) begin
            if (sb == 0) return {1'b1, 64'b0};
            q = sa / sb;
            r = sa % sb;
            return {1'b0, ((64'(r) & mw) << w) | (64'(q) & mw)};
        end
        p = 64'(sa * sb);
        if (op[2]) p = op[1] ? acc - p : acc + p;
        return {1'b0, p & m2};
    endfunction

    task automatic do_op(input logic w8, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] acc, output logic [63:0] got);
        int          w;
        int          lat;
        logic [64:0] e;
        w = w8 ? 8 : 32;
        e = model(w, op, a, b, acc);
        sel8 = w8;
        op_r = op;
        a_r = a;
        b_r = b;
        acc_r = acc;
        start_r = 1'b1;
        lat = 0;
        for (int n = 1; n <= 3 * w; n++) begin
            tick();
            if (n == 1) begin
                chk("busy", 64'(busy_m), 64'(!e[64]));
                op_r = 3'($urandom);
                a_r = $urandom;
                b_r = $urandom;
                acc_r = {$urandom, $urandom};
            end
            if (rdy_m) begin
                lat = n;
                break;
            end
        end
        got = res_m;
        chk("latency", 64'(lat), e[64] ? 64'd1 : 64'(w + 1));
        chk("result", res_m, e[63:0]);
        chk("dz", 64'(dz_m), 64'(e[64]));
        tick();
        chk("hold_rdy", 64'(rdy_m), 64'd1);
        chk("hold_res", res_m, e[63:0]);
        start_r = 1'b0;
        tick();
        chk("drop_rdy", 64'(rdy_m), 64'd0);
        chk("drop_res", res_m, 64'd0);
        chk("drop_dz", 64'(dz_m), 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        logic        seen;
        logic [31:0] a, b;
        rst = 1'b1;
        start_r = 1'b0;
        annul_r = 1'b0;
        sel8 = 1'b0;
        op_r = '0;
        a_r = '0;
        b_r = '0;
        acc_r = '0;
        tick();
        tick();
        chk("rst_res32", if32.result_o, 64'd0);
        chk("rst_flags32", {61'b0, if32.ready_o, if32.busy_o, if32.dz_o}, 64'd0);
        chk("rst_res8", {48'b0, if8.result_o}, 64'd0);
        chk("rst_flags8", {61'b0, if8.ready_o, if8.busy_o, if8.dz_o}, 64'd0);
        rst = 1'b0;
        tick();

        do_op(1'b0, 3'b011, 32'hFFFFFFF9, 32'd2, 64'd0, got);
        chk("tp_div", got, 64'hFFFFFFFF_FFFFFFFD);
        do_op(1'b0, 3'b001, 32'hFFFFFFFF, 32'd2, 64'd0, got);
        chk("tp_mult", got, 64'hFFFFFFFF_FFFFFFFE);
        do_op(1'b0, 3'b000, 32'hFFFFFFFF, 32'd2, 64'd0, got);
        chk("tp_multu", got, 64'h00000001_FFFFFFFE);
        do_op(1'b0, 3'b111, 32'd3, 32'd4, 64'd10, got);
        chk("tp_msub", got, 64'hFFFFFFFF_FFFFFFFE);
        do_op(1'b0, 3'b100, 32'd1, 32'd1, '1, got);
        chk("tp_maddu", got, 64'd0);
        do_op(1'b0, 3'b010, 32'd5, 32'd0, 64'd0, got);
        chk("tp_divz", got, 64'd0);
        do_op(1'b0, 3'b011, 32'h80000000, 32'hFFFFFFFF, 64'd0, got);
        chk("tp_divovf", got, 64'h00000000_80000000);

        sel8 = 1'b0;
        op_r = 3'b011;
        a_r = 32'h12345678;
        b_r = 32'd9;
        start_r = 1'b1;
        for (int n = 1; n <= 10; n++) tick();
        annul_r = 1'b1;
        tick();
        annul_r = 1'b0;
        start_r = 1'b0;
        chk("annul_busy", 64'(busy_m), 64'd0);
        chk("annul_rdy", 64'(rdy_m), 64'd0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            seen = seen | rdy_m;
        end
        chk("annul_nordy", 64'(seen), 64'd0);
        do_op(1'b0, 3'b010, 32'd100, 32'd7, 64'd0, got);
        chk("tp_after_annul", got, 64'h00000002_0000000E);

        op_r = 3'b001;
        a_r = 32'h7;
        b_r = 32'h9;
        start_r = 1'b1;
        for (int n = 1; n <= 5; n++) tick();
        rst = 1'b1;
        start_r = 1'b0;
        tick();
        chk("midrst_res", res_m, 64'd0);
        chk("midrst_flags", {61'b0, rdy_m, busy_m, dz_m}, 64'd0);
        rst = 1'b0;
        tick();

        do_op(1'b1, 3'b001, 32'h80, 32'h80, 64'd0, got);
        chk("tp8_mult", got, 64'h4000);
        do_op(1'b1, 3'b011, 32'h81, 32'h03, 64'd0, got);
        chk("tp8_div", got, 64'hFFD6);
        do_op(1'b1, 3'b011, 32'h80, 32'hFF, 64'd0, got);
        chk("tp8_divovf", got, 64'h0080);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = '1;
                2: a = 32'h80000080;
                default: ;
            endcase
            do_op(1'(i & 1), 3'($urandom), a, b, {$urandom, $urandom}, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
